pkt_fifo_scheduler: RTL and testbench

- Shares the packet FIFO (scalable_data_structure) between NUM_REQ producers using a round-robin push arbiter.
- Stamps each accepted packet with a sequential id.
- Sequences FIFO pops into a registered valid/ready egress port.
- Sits between the producer interfaces and the FIFO; the FIFO's push/pop/id/src/dest/payload pins connect to this block only.

---
 rtl/pkt_fifo_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pkt_fifo_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo_scheduler.sv
// Round-robin push arbiter, sequence-id stamper and egress sequencer that sits
// between NUM_REQ producers and a shared packet FIFO.
module pkt_fifo_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int ID_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_src,
  input  logic [NUM_REQ*DATA_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_payload,
  output logic                      fifo_push,
  output logic [ID_W-1:0]           fifo_id,
  output logic [DATA_W-1:0]         fifo_src,
  output logic [DATA_W-1:0]         fifo_dest,
  output logic [DATA_W-1:0]         fifo_payload,
  input  logic                      fifo_full,
  output logic                      fifo_pop,
  input  logic                      fifo_empty,
  input  logic [ID_W-1:0]           fifo_out_id,
  input  logic [DATA_W-1:0]         fifo_out_src,
  input  logic [DATA_W-1:0]         fifo_out_dest,
  input  logic [DATA_W-1:0]         fifo_out_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_id,
  output logic [DATA_W-1:0]         out_src,
  output logic [DATA_W-1:0]         out_dest,
  output logic [DATA_W-1:0]         out_payload,
  output logic [NUM_REQ*16-1:0]     grant_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} egress_state_t;

  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] scan_idx_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic             accept_s;
  logic [ID_W-1:0]  id_r;
  logic [15:0]      cnt_r [NUM_REQ];
  egress_state_t    state_r;
  egress_state_t    state_nxt_s;
  logic             pop_s;

  // Descending scan so the hit nearest rr_ptr_r is the last one written.
  always_comb begin
    grant_idx_s = '0;
    scan_idx_s  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      if (req_valid[scan_idx_s]) begin
        grant_idx_s = scan_idx_s;
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  assign accept_s   = rst_n & (|req_valid) & ~fifo_full;
  assign next_ptr_s = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + PTR_W'(1);

  // Ingress strobes and the granted requester's fields toward the FIFO.
  always_comb begin
    req_ready    = '0;
    fifo_push    = 1'b0;
    fifo_id      = '0;
    fifo_src     = '0;
    fifo_dest    = '0;
    fifo_payload = '0;
    if (accept_s) begin
      req_ready[grant_idx_s] = 1'b1;
      fifo_push    = 1'b1;
      fifo_id      = id_r;
      fifo_src     = req_src[int'(grant_idx_s)*DATA_W +: DATA_W];
      fifo_dest    = req_dest[int'(grant_idx_s)*DATA_W +: DATA_W];
      fifo_payload = req_payload[int'(grant_idx_s)*DATA_W +: DATA_W];
    end else begin
      fifo_push = 1'b0;
    end
  end

  // Pointer, id counter and saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
      id_r     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_r[i] <= 16'd0;
      end
    end else if (accept_s) begin
      rr_ptr_r <= next_ptr_s;
      id_r     <= id_r + ID_W'(1);
      if (cnt_r[grant_idx_s] != 16'hFFFF) begin
        cnt_r[grant_idx_s] <= cnt_r[grant_idx_s] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_r[g];
  end

  // Egress next state; the pop strobe never fires in WAIT.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          pop_s       = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: state_nxt_s = HOLD;
      HOLD: begin
        if (out_ready && !fifo_empty) begin
          pop_s       = 1'b1;
          state_nxt_s = WAIT;
        end else if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign fifo_pop = pop_s & rst_n;

  // Egress registers: head is captured one cycle after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_src     <= '0;
      out_dest    <= '0;
      out_payload <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        WAIT: begin
          out_valid   <= 1'b1;
          out_id      <= fifo_out_id;
          out_src     <= fifo_out_src;
          out_dest    <= fifo_out_dest;
          out_payload <= fifo_out_payload;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= out_valid;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_fifo_scheduler.sv
// Directed bench for pkt_fifo_scheduler with a behavioural FIFO whose head
// fields are valid the cycle after a pop.
module tb_pkt_fifo_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 128;
  localparam int ID_W    = 32;
  localparam int DEPTH   = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_src, req_dest, req_payload;
  logic                      fifo_push, fifo_full, fifo_pop, fifo_empty;
  logic [ID_W-1:0]           fifo_id, fifo_out_id, out_id;
  logic [DATA_W-1:0]         fifo_src, fifo_dest, fifo_payload;
  logic [DATA_W-1:0]         fifo_out_src, fifo_out_dest, fifo_out_payload;
  logic                      out_valid, out_ready;
  logic [DATA_W-1:0]         out_src, out_dest, out_payload;
  logic [NUM_REQ*16-1:0]     grant_cnt;

  pkt_fifo_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dest(req_dest), .req_payload(req_payload),
    .fifo_push(fifo_push), .fifo_id(fifo_id), .fifo_src(fifo_src),
    .fifo_dest(fifo_dest), .fifo_payload(fifo_payload), .fifo_full(fifo_full),
    .fifo_pop(fifo_pop), .fifo_empty(fifo_empty), .fifo_out_id(fifo_out_id),
    .fifo_out_src(fifo_out_src), .fifo_out_dest(fifo_out_dest),
    .fifo_out_payload(fifo_out_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_src(out_src), .out_dest(out_dest), .out_payload(out_payload),
    .grant_cnt(grant_cnt)
  );

  // Behavioural FIFO model
  logic [ID_W+3*DATA_W-1:0] mem [DEPTH];
  int   wr_ptr, rd_ptr, count;
  logic full_force;
  logic underflow;

  assign fifo_empty = (count == 0);
  assign fifo_full  = full_force | (count >= DEPTH);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 0; rd_ptr <= 0; count <= 0; underflow <= 1'b0;
      fifo_out_id <= '0; fifo_out_src <= '0; fifo_out_dest <= '0; fifo_out_payload <= '0;
    end else begin
      if (fifo_push) begin
        mem[wr_ptr % DEPTH] <= {fifo_id, fifo_src, fifo_dest, fifo_payload};
        wr_ptr <= wr_ptr + 1;
      end
      if (fifo_pop) begin
        {fifo_out_id, fifo_out_src, fifo_out_dest, fifo_out_payload} <= mem[rd_ptr % DEPTH];
        rd_ptr <= rd_ptr + 1;
        if (count == 0) underflow <= 1'b1;
      end
      count <= count + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic        full;
    logic [3:0]  exp_ready;
    logic        exp_push;
    logic [31:0] exp_id;
    int          exp_g;
  } vec_t;

  vec_t vecs[25];
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [DATA_W-1:0] src_of(input int g);
    return 128'h5A00_0000 + DATA_W'(g);
  endfunction
  function automatic logic [DATA_W-1:0] dest_of(input int g);
    return 128'hDE00_0000 + DATA_W'(g);
  endfunction
  function automatic logic [DATA_W-1:0] pay_of(input int g);
    return 128'hBA00_0000 + DATA_W'(g);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] v, input logic f, input logic [3:0] r,
                         input logic p, input logic [31:0] id, input int g);
    vecs[n_vec].valid = v;  vecs[n_vec].full = f;  vecs[n_vec].exp_ready = r;
    vecs[n_vec].exp_push = p; vecs[n_vec].exp_id = id; vecs[n_vec].exp_g = g;
    n_vec++;
  endtask

  task automatic init_fields();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_src[k*DATA_W +: DATA_W]     = src_of(k);
      req_dest[k*DATA_W +: DATA_W]    = dest_of(k);
      req_payload[k*DATA_W +: DATA_W] = pay_of(k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; full_force = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      req_valid  = vecs[i].valid;
      full_force = vecs[i].full;
      #1;
      check($sformatf("v%0d_ready", i), 128'(req_ready), 128'(vecs[i].exp_ready));
      check($sformatf("v%0d_push", i), 128'(fifo_push), 128'(vecs[i].exp_push));
      if (vecs[i].exp_push) begin
        check($sformatf("v%0d_id", i), 128'(fifo_id), 128'(vecs[i].exp_id));
        check($sformatf("v%0d_src", i), fifo_src, src_of(vecs[i].exp_g));
        check($sformatf("v%0d_dest", i), fifo_dest, dest_of(vecs[i].exp_g));
        check($sformatf("v%0d_pay", i), fifo_payload, pay_of(vecs[i].exp_g));
      end else begin
        check($sformatf("v%0d_src_idle", i), fifo_src, 128'd0);
      end
    end
    @(negedge clk);
    req_valid = '0; full_force = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_n, last_c, miss, pops;

    // all four requesters valid: strict rotation
    for (int i = 0; i < 12; i++) add_vec(4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b1, 32'(i), i % 4);
    // lone requester 2 back-to-back, then pointer sits at 3
    for (int i = 0; i < 5; i++) add_vec(4'b0100, 1'b0, 4'b0100, 1'b1, 32'(i), 2);
    add_vec(4'b1111, 1'b0, 4'b1000, 1'b1, 32'd5, 3);
    // full blocks everything, then 1 and 3 alternate from pointer 0
    for (int i = 0; i < 3; i++) add_vec(4'b1010, 1'b1, 4'b0000, 1'b0, 32'd0, 0);
    add_vec(4'b1010, 1'b0, 4'b0010, 1'b1, 32'd0, 1);
    add_vec(4'b1010, 1'b0, 4'b1000, 1'b1, 32'd1, 3);
    add_vec(4'b1010, 1'b0, 4'b0010, 1'b1, 32'd2, 1);
    add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 32'd0, 0);

    rst_n = 1'b0; req_valid = 4'b1111; full_force = 1'b0; out_ready = 1'b1;
    init_fields();
    #2;
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_push", 128'(fifo_push), 128'd0);
    check("rst_pop", 128'(fifo_pop), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_id", 128'(out_id), 128'd0);
    check("rst_grant_cnt", 128'(grant_cnt), 128'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;

    run_vecs(0, 12);
    check("cnt_rotation", 128'(grant_cnt), 128'(64'h0003_0003_0003_0003));
    do_reset();
    run_vecs(12, 18);
    check("cnt_single", 128'(grant_cnt), 128'(64'h0001_0005_0000_0000));
    do_reset();
    run_vecs(18, 25);

    // 1000 packets queued behind a stalled consumer, then drained
    do_reset();
    out_ready = 1'b0;
    miss = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      req_payload[0 +: DATA_W] = DATA_W'(i);
      #1;
      if (!fifo_push || fifo_id != 32'(i)) miss++;
    end
    @(negedge clk);
    req_valid = '0;
    check("bulk_push_miss", 128'(miss), 128'd0);
    out_ready = 1'b1;
    exp_n = 0; last_c = 0;
    for (int c = 0; c < 4000 && exp_n < 1000; c++) begin
      if (out_valid) begin
        check($sformatf("bulk_id%0d", exp_n), 128'(out_id), 128'(exp_n));
        check($sformatf("bulk_pay%0d", exp_n), out_payload, 128'(exp_n));
        if (exp_n > 0) check($sformatf("bulk_gap%0d", exp_n), 128'(c - last_c), 128'd2);
        last_c = c;
        exp_n++;
      end
      @(negedge clk);
    end
    check("bulk_count", 128'(exp_n), 128'd1000);
    repeat (3) @(negedge clk);
    check("bulk_empty", 128'(fifo_empty), 128'd1);
    check("bulk_valid_end", 128'(out_valid), 128'd0);
    check("bulk_pop_end", 128'(fifo_pop), 128'd0);
    check("bulk_underflow", 128'(underflow), 128'd0);
    init_fields();

    // id wrap, stalled HOLD, then reset while holding
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    force dut.id_r = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.id_r;
    req_valid = 4'b0001;
    req_payload[0 +: DATA_W] = 128'hCAFE;
    #1;
    check("wrap_push0", 128'(fifo_push), 128'd1);
    check("wrap_id0", 128'(fifo_id), 128'(32'hFFFF_FFFF));
    @(negedge clk);
    req_payload[0 +: DATA_W] = 128'hBEEF;
    #1;
    check("wrap_push1", 128'(fifo_push), 128'd1);
    check("wrap_id1", 128'(fifo_id), 128'd0);
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    check("hold_valid", 128'(out_valid), 128'd1);
    check("hold_id", 128'(out_id), 128'(32'hFFFF_FFFF));
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_pop) pops++;
      check($sformatf("stall_id%0d", c), 128'(out_id), 128'(32'hFFFF_FFFF));
      check($sformatf("stall_pay%0d", c), out_payload, 128'hCAFE);
    end
    check("stall_pops", 128'(pops), 128'd0);
    out_ready = 1'b1;
    #1;
    check("release_pop", 128'(fifo_pop), 128'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_gap", 128'(out_valid), 128'd0);
    check("release_nopop", 128'(fifo_pop), 128'd0);
    @(negedge clk);
    check("next_valid", 128'(out_valid), 128'd1);
    check("next_id", 128'(out_id), 128'd0);
    check("next_pay", out_payload, 128'hBEEF);

    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_out_id", 128'(out_id), 128'd0);
    check("midrst_push", 128'(fifo_push), 128'd0);
    check("midrst_ready", 128'(req_ready), 128'd0);
    check("midrst_cnt", 128'(grant_cnt), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", 128'(req_ready), 128'd1);
    check("postrst_id", 128'(fifo_id), 128'd0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
